icache_multi_fetch: RTL
=======================

// Module: icache_multi_fetch
// PURPOSE
//  Parametrised next-generation vanilla-core instruction cache: returns up to fetch_width_p
//  consecutive instructions per cycle from one block. Adds per-line valid bits (cleared on reset
//  and flush), sequenced block-fill FSM with error detection, and a per-slot valid mask for
//  groups clipped at the block end. Sits between the fetch/next-PC logic and the remote icache-fill path.
// PARAMETERS
//  icache_tag_width_p            12    tag bits per line
//  icache_entries_p              1024  total instruction words (power of 2)
//  icache_block_size_in_words_p  4     words per line (power of 2, >=2)
//  fetch_width_p                 2     instrs per fetch group (power of 2, <= block size)
//  pc_width_lp (local)           icache_tag_width_p + clog2(icache_entries_p), word address
// PORTS
//  clk_i           in   1                 clock
//  reset_n_i       in   1                 reset, synchronous, active-low
//  v_i             in   1                 access valid
//  w_i             in   1                 1 = fill write, 0 = fetch read
//  flush_i         in   1                 invalidate all lines
//  read_seq_i      in   1                 hint: next pc = pc_r + fetch_width_p
//  w_pc_i          in   pc_width_lp       fill word address
//  w_instr_i       in   32                fill instruction
//  pc_i            in   pc_width_lp       fetch word address
//  instr_o         out  fetch_width_p*32  fetch group, slot 0 = pc_r
//  instr_v_o       out  fetch_width_p     per-slot valid mask
//  branch_neg_o    out  fetch_width_p     slot is BRANCH with negative imm (backward-taken prediction)
//  pc_r_o          out  pc_width_lp       registered fetch pc
//  icache_miss_o   out  1                 tag mismatch or line invalid
//  icache_flush_r_o out 1                 registered flush
//  fill_err_o      out  1                 sticky: out-of-sequence fill seen
// BEHAVIOUR
//  Reset (reset_n_i=0 at posedge): pc_r=0, flush_r=0, all valid bits=0, fill FSM=IDLE, count=0,
//   fill_err_o=0. After reset icache_miss_o=1 for any pc (line invalid). Reset mid-fill discards buffer.
//  Fetch: v_i&~w_i latches pc_r<=pc_i, flush_r<=0; data on outputs next cycle (1-cycle latency).
//   Memory read latches last data (latch_last_read), so outputs hold when no read issued.
//   Read enable = v_i&~w_i & (~read_seq_i | offset(pc_r)+fetch_width_p >= block size).
//  Slot k: word offset(pc_r)+k; instr_v_o[k]=1 iff offset(pc_r)+k < block size (no cross-block);
//   invalid slots drive 0. instr_v_o=0 when icache_miss_o=1.
//  icache_miss_o = ~valid[line(pc_r)] | tag != pc_r tag field; valid sampled in fetch cycle.
//  Fill FSM IDLE->FILL on v_i&w_i with offset 0; each write buffers word, count++.
//   Write at offset block-1: whole line + tag written to memory, valid[line]<=1, ->IDLE, count=0.
//   Write with offset != count: fill_err_o<=1 (sticky), buffer dropped, count=0, ->IDLE, no memory write.
//   While w_i=1 fetch reads are suppressed (write has priority); pc_r holds.
//  Flush: v_i&w_i=0 cycles: flush_i clears all valid bits next edge; flush_r<=flush_i when no fetch.
//   flush_i during FILL: valid cleared, fill continues and completing line becomes valid.
//   flush_i same cycle as line completion: completing line ends valid (set wins).
//  branch_neg_o[k] = instr_v_o[k] & op==BRANCH & instr[31].
//  Widths: offset = clog2(block); line index = clog2(entries/block); fetch offset add is
//   offset-width+1 bits so the end-of-block compare cannot wrap.
// STRUCTURE
//  Package bsg_vanilla_pkg: icache_line_s (tag, instr[block]), fetch-width helper constants,
//   fill-state enum {IDLE, FILL}.
//  Sub-module: icache_fill_buffer (FSM, counter, word buffer, error detect); data array via
//   bsg_mem_1rw_sync; valid bits as a flop vector in the top.
// TESTING
//  1 reset, fetch pc=0x000 -> icache_miss_o=1, instr_v_o=0, fill_err_o=0.
//  2 fill words 0x40..0x43 then fetch pc=0x41, fw=2 -> instr_o={w41,w42}, instr_v_o=2'b11, miss=0.
//  3 fetch pc=0x43 -> instr_v_o=2'b01, slot1=0; fetch 0x80 (unfilled line) -> miss=1.
//  4 fill offsets 0,2 -> fill_err_o=1 after 2nd write, line stays invalid (miss=1), refill 0..3 -> miss=0.
//  5 filled line, flush_i 1 cycle -> icache_flush_r_o=1 next cycle, fetch same pc -> miss=1.
//  6 reset_n_i low after 2 fill words, refill 0..3 -> line valid, no fill_err_o; branch imm<0 slot -> branch_neg_o=1.

Source files
------------

// File: rtl/icache_multi_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_multi_fetch_pkg
//  Purpose  : Shared types and constants for the multi-fetch icache:
//             - fill-state enum {IDLE, FILL}
//             - BRANCH opcode and the backward-branch detect helper
//  Revision : 1.0  initial release
// ============================================================================
package icache_multi_fetch_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    localparam logic [6:0] c_op_branch = 7'b1100011;

    // The sign bit of a B-type immediate sits in instr[31], so a set bit
    // means a backward branch, which the front end predicts taken.
    function automatic logic is_branch_neg(input logic [31:0] instr);
        return (instr[6:0] == c_op_branch) && instr[31];
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_multi_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_multi_fetch_if
//  Purpose  : Fetch/fill bus between the next-PC logic (master) and the
//             icache (slave).
//  Ports    : v_i, w_i, flush_i, read_seq_i, w_pc_i, w_instr_i, pc_i  (to cache)
//             instr_o, instr_v_o, branch_neg_o, pc_r_o, icache_miss_o,
//             icache_flush_r_o, fill_err_o                             (from cache)
//  Revision : 1.0  initial release
// ============================================================================
interface icache_multi_fetch_if #(
    parameter int pc_width_p    = 22,
    parameter int fetch_width_p = 2
);
    logic                        v_i;
    logic                        w_i;
    logic                        flush_i;
    logic                        read_seq_i;
    logic [pc_width_p-1:0]       w_pc_i;
    logic [31:0]                 w_instr_i;
    logic [pc_width_p-1:0]       pc_i;
    logic [fetch_width_p*32-1:0] instr_o;
    logic [fetch_width_p-1:0]    instr_v_o;
    logic [fetch_width_p-1:0]    branch_neg_o;
    logic [pc_width_p-1:0]       pc_r_o;
    logic                        icache_miss_o;
    logic                        icache_flush_r_o;
    logic                        fill_err_o;

    modport master (
        output v_i, w_i, flush_i, read_seq_i, w_pc_i, w_instr_i, pc_i,
        input  instr_o, instr_v_o, branch_neg_o, pc_r_o, icache_miss_o,
               icache_flush_r_o, fill_err_o
    );

    modport slave (
        input  v_i, w_i, flush_i, read_seq_i, w_pc_i, w_instr_i, pc_i,
        output instr_o, instr_v_o, branch_neg_o, pc_r_o, icache_miss_o,
               icache_flush_r_o, fill_err_o
    );
endinterface
`default_nettype wire

// File: rtl/icache_multi_fetch_fill_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fill_buffer
//  Purpose  : Collects the words of one cache line written in strict offset
//             order. Flags (sticky) any out-of-order word and drops the
//             partial line.
//  Ports    : clk_i, reset_n_i  clock, synchronous active-low reset
//             wr_v_i            fill write strobe
//             wr_off_i          word offset of the write
//             wr_instr_i        fill word
//             line_done_o       last word accepted this cycle (write memory)
//             line_o            full line, last word taken from wr_instr_i
//             fill_err_o        sticky out-of-sequence flag
//  Revision : 1.0  initial release
// ============================================================================
module icache_fill_buffer
    import icache_multi_fetch_pkg::*;
#(
    parameter int block_words_p = 4
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    wr_v_i,
    input  logic [$clog2(block_words_p)-1:0]        wr_off_i,
    input  logic [31:0]                             wr_instr_i,
    output logic                                    line_done_o,
    output logic [block_words_p-1:0][31:0]          line_o,
    output logic                                    fill_err_o
);
    localparam int                 c_off_w = $clog2(block_words_p);
    localparam logic [c_off_w-1:0] c_last  = c_off_w'(block_words_p - 1);

    fill_state_e                      r_state;
    logic [c_off_w-1:0]               r_count;
    logic [block_words_p-2:0][31:0]   r_buf;
    logic                             r_err;

    logic [c_off_w-1:0] w_expect;
    logic               w_in_seq;

    assign w_expect    = (r_state == FILL) ? r_count : '0;
    assign w_in_seq    = (wr_off_i == w_expect);
    // Gated by reset so a write coinciding with reset never lands in memory.
    assign line_done_o = reset_n_i & wr_v_i & w_in_seq & (wr_off_i == c_last);
    assign fill_err_o  = r_err;

    for (genvar k = 0; k < block_words_p - 1; k++) begin : g_line
        assign line_o[k] = r_buf[k];
    end
    assign line_o[block_words_p-1] = wr_instr_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (wr_v_i) begin
            if (!w_in_seq) begin
                r_err   <= 1'b1;
                r_count <= '0;
                r_state <= IDLE;
            end else if (wr_off_i == c_last) begin
                r_count <= '0;
                r_state <= IDLE;
            end else begin
                r_buf[r_count] <= wr_instr_i;
                r_count        <= r_count + 1'b1;
                r_state        <= FILL;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache_multi_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : icache_multi_fetch
//  Purpose  : Instruction cache returning up to fetch_width_p consecutive
//             words of one line per cycle, with per-line valid bits,
//             ordered line fill and a per-slot valid mask.
//  Ports    : clk_i      clock
//             reset_n_i  synchronous active-low reset
//             ic         icache_multi_fetch_if.slave (fetch/fill bus)
//  Revision : 1.0  initial release
// ============================================================================
module icache_multi_fetch
    import icache_multi_fetch_pkg::*;
#(
    parameter int  icache_tag_width_p           = 12,
    parameter int  icache_entries_p             = 1024,
    parameter int  icache_block_size_in_words_p = 4,
    parameter int  fetch_width_p                = 2,
    localparam int pc_width_lp = icache_tag_width_p + $clog2(icache_entries_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    icache_multi_fetch_if.slave  ic
);
    localparam int c_block = icache_block_size_in_words_p;
    localparam int c_off_w = $clog2(c_block);
    localparam int c_lines = icache_entries_p / c_block;
    localparam int c_idx_w = $clog2(c_lines);
    localparam int c_tag_w = icache_tag_width_p;
    // One extra bit keeps the end-of-block compare from wrapping.
    localparam logic [c_off_w:0] c_block_ext = (c_off_w+1)'(c_block);
    localparam logic [c_off_w:0] c_fw_ext    = (c_off_w+1)'(fetch_width_p);

    typedef struct packed {
        logic [c_tag_w-1:0]          tag;
        logic [c_block-1:0][31:0]    instr;
    } icache_line_s;

    icache_line_s              r_mem [c_lines];
    icache_line_s              r_rd_line;
    logic                      r_rd_line_v;
    logic [c_lines-1:0]        r_valid;
    logic [pc_width_lp-1:0]    r_pc;
    logic                      r_flush;

    logic                      w_fetch;
    logic                      w_wr;
    logic                      w_seq_end;
    logic                      w_rd_en;
    logic                      w_miss;
    logic [c_off_w-1:0]        w_pc_r_off;
    logic [c_tag_w-1:0]        w_pc_r_tag;
    logic [c_idx_w-1:0]        w_rd_idx;
    logic [c_idx_w-1:0]        w_wr_idx;
    logic [c_tag_w-1:0]        w_wr_tag;
    logic                      w_line_done;
    logic [c_block-1:0][31:0]  w_fill_line;
    logic [fetch_width_p-1:0]  w_slot_v;

    assign w_fetch    = ic.v_i & ~ic.w_i;
    assign w_wr       = ic.v_i &  ic.w_i;
    assign w_pc_r_off = r_pc[c_off_w-1:0];
    assign w_pc_r_tag = r_pc[pc_width_lp-1 -: c_tag_w];
    assign w_rd_idx   = ic.pc_i[c_off_w +: c_idx_w];
    assign w_wr_idx   = ic.w_pc_i[c_off_w +: c_idx_w];
    assign w_wr_tag   = ic.w_pc_i[pc_width_lp-1 -: c_tag_w];

    // A sequential fetch that stays inside the current line reuses the
    // latched line; only a line crossing needs a new array read.
    assign w_seq_end  = ({1'b0, w_pc_r_off} + c_fw_ext) >= c_block_ext;
    assign w_rd_en    = w_fetch & (~ic.read_seq_i | w_seq_end);

    assign w_miss     = ~r_rd_line_v | (r_rd_line.tag != w_pc_r_tag);

    icache_fill_buffer #(
        .block_words_p (c_block)
    ) u_fill (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .wr_v_i      (w_wr),
        .wr_off_i    (ic.w_pc_i[c_off_w-1:0]),
        .wr_instr_i  (ic.w_instr_i),
        .line_done_o (w_line_done),
        .line_o      (w_fill_line),
        .fill_err_o  (ic.fill_err_o)
    );

    // Data array: synchronous read that holds its last value when idle.
    always_ff @(posedge clk_i) begin
        if (w_rd_en) begin
            r_rd_line <= r_mem[w_rd_idx];
        end
        if (w_line_done) begin
            r_mem[w_wr_idx] <= {w_wr_tag, w_fill_line};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_pc        <= '0;
            r_flush     <= 1'b0;
            r_valid     <= '0;
            r_rd_line_v <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_pc    <= ic.pc_i;
                r_flush <= 1'b0;
            end else begin
                r_flush <= ic.flush_i;
            end
            if (w_rd_en) begin
                r_rd_line_v <= r_valid[w_rd_idx];
            end
            if (ic.flush_i) begin
                r_valid <= '0;
            end
            // Later assignment: a completing line survives a same-cycle flush.
            if (w_line_done) begin
                r_valid[w_wr_idx] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < fetch_width_p; k++) begin : g_slot
        logic [c_off_w:0] w_slot_off;
        logic [31:0]      w_slot_instr;

        assign w_slot_off   = {1'b0, w_pc_r_off} + (c_off_w+1)'(k);
        // Slots past the end of the line are clipped, never wrapped.
        assign w_slot_v[k]  = ~w_miss & (w_slot_off < c_block_ext);
        assign w_slot_instr = w_slot_v[k] ? r_rd_line.instr[w_slot_off[c_off_w-1:0]] : '0;
        assign ic.instr_o[k*32 +: 32] = w_slot_instr;
        assign ic.branch_neg_o[k]     = w_slot_v[k] & is_branch_neg(w_slot_instr);
    end

    assign ic.instr_v_o        = w_slot_v;
    assign ic.pc_r_o           = r_pc;
    assign ic.icache_miss_o    = w_miss;
    assign ic.icache_flush_r_o = r_flush;

endmodule
`default_nettype wire
